// File: rtl/uart_tx_engine_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_engine_if
// Description : Write-side bus between the AHB register front end and the
//               UART transmit engine.
//                 wr_en / wr_data : push one byte into the TX FIFO
//                 ovf_clr         : clear the sticky overflow flag
//                 fifo_full / fifo_empty / fifo_level : FIFO occupancy
//                 ovf_err         : sticky "write dropped" flag
//               master = front end (drives writes), slave = transmit engine.
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_tx_engine_if #(
    parameter int FIFO_DEPTH = 8
);
    localparam int c_lvl_w = $clog2(FIFO_DEPTH) + 1;

    logic               wr_en;
    logic [7:0]         wr_data;
    logic               ovf_clr;
    logic               fifo_full;
    logic               fifo_empty;
    logic [c_lvl_w-1:0] fifo_level;
    logic               ovf_err;

    modport master (
        output wr_en,
        output wr_data,
        output ovf_clr,
        input  fifo_full,
        input  fifo_empty,
        input  fifo_level,
        input  ovf_err
    );

    modport slave (
        input  wr_en,
        input  wr_data,
        input  ovf_clr,
        output fifo_full,
        output fifo_empty,
        output fifo_level,
        output ovf_err
    );
endinterface
`default_nettype wire

// File: rtl/uart_tx_engine.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_engine
// Description : UART transmit stage. Bytes written over the wr_bus interface
//               are buffered in a FIFO_DEPTH-entry synchronous FIFO and sent
//               on txd as 8N1 frames, or 8E1 when UART_TX_PARITY_EN is
//               defined (even parity bit between data and stop).
//               Every bit lasts baud_div+1 hclk cycles; baud_div is sampled
//               only when a frame starts.
// Ports       : hclk      - system clock, rising edge
//               hrst_n    - asynchronous active-low reset
//               wr_bus    - write bus (slave modport): wr_en, wr_data,
//                           ovf_clr, fifo_full, fifo_empty, fifo_level,
//                           ovf_err
//               baud_div  - bit period minus one, in hclk cycles
//               tx_en     - permits new frames to start
//               txd       - serial output, idle high, registered
//               tx_busy   - a frame is in progress
//               tx_done   - one-cycle pulse on the last stop-bit cycle
// Macros      : UART_TX_PARITY_EN - adds the even-parity bit (11-bit frames)
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_engine #(
    parameter int FIFO_DEPTH = 8,   // power of two, >= 2
    parameter int DIV_WIDTH  = 16
) (
    input  logic                 hclk,
    input  logic                 hrst_n,
    uart_tx_engine_if.slave      wr_bus,
    input  logic [DIV_WIDTH-1:0] baud_div,
    input  logic                 tx_en,
    output logic                 txd,
    output logic                 tx_busy,
    output logic                 tx_done
);

    localparam int                 c_aw      = $clog2(FIFO_DEPTH);
    localparam logic [DIV_WIDTH-1:0] c_div_one = {{(DIV_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        S_PARITY = 3'd3,
`endif
        S_STOP   = 3'd4
    } state_t;

    // ------------------------------------------------------------------------
    // FIFO storage and pointers (extra MSB on each pointer tells full from
    // empty when the index bits match)
    // ------------------------------------------------------------------------
    logic [7:0]    r_mem [FIFO_DEPTH];
    logic [c_aw:0] r_wr_ptr;
    logic [c_aw:0] r_rd_ptr;
    logic          r_ovf_err;

    logic          w_empty;
    logic          w_full;
    logic          w_push;
    logic          w_pop;
    logic [7:0]    w_head;

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[c_aw] != r_rd_ptr[c_aw]) &&
                     (r_wr_ptr[c_aw-1:0] == r_rd_ptr[c_aw-1:0]);
    assign w_head  = r_mem[r_rd_ptr[c_aw-1:0]];

    // A write into a full FIFO still lands when a pop frees the head slot in
    // the same cycle. The FIFO can never be empty and popped at once, so no
    // write-through bypass is needed.
    assign w_push  = wr_bus.wr_en && (!w_full || w_pop);

    always_ff @(posedge hclk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[c_aw-1:0]] <= wr_bus.wr_data;
        end
    end

    always_ff @(posedge hclk or negedge hrst_n) begin
        if (!hrst_n) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_ovf_err <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            // Clear wins over a same-cycle dropped write.
            if (wr_bus.ovf_clr) begin
                r_ovf_err <= 1'b0;
            end else if (wr_bus.wr_en && w_full && !w_pop) begin
                r_ovf_err <= 1'b1;
            end
        end
    end

    assign wr_bus.fifo_full  = w_full;
    assign wr_bus.fifo_empty = w_empty;
    assign wr_bus.fifo_level = r_wr_ptr - r_rd_ptr;
    assign wr_bus.ovf_err    = r_ovf_err;

    // ------------------------------------------------------------------------
    // Transmit FSM
    // ------------------------------------------------------------------------
    state_t               r_state;
    logic [DIV_WIDTH-1:0] r_cnt;       // cycle within the current bit
    logic [DIV_WIDTH-1:0] r_div_q;     // divisor latched at frame start
    logic [7:0]           r_shift;     // r_shift[0] is the bit on the line
    logic [2:0]           r_bit_idx;
    logic                 r_txd;
    logic                 r_busy;
    logic                 r_done;
`ifdef UART_TX_PARITY_EN
    logic                 r_parity;
`endif

    logic w_bit_end;

    assign w_bit_end = (r_cnt == r_div_q);

    // Pop from IDLE, or on the final stop cycle so back-to-back frames have
    // no idle gap.
    assign w_pop = tx_en && !w_empty &&
                   ((r_state == S_IDLE) || ((r_state == S_STOP) && w_bit_end));

    always_ff @(posedge hclk or negedge hrst_n) begin
        if (!hrst_n) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_div_q   <= '0;
            r_shift   <= '0;
            r_bit_idx <= '0;
            r_txd     <= 1'b1;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
`ifdef UART_TX_PARITY_EN
            r_parity  <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_state   <= S_START;
                        r_cnt     <= '0;
                        r_div_q   <= baud_div;
                        r_shift   <= w_head;
`ifdef UART_TX_PARITY_EN
                        r_parity  <= ^w_head;
`endif
                        r_txd     <= 1'b0;
                        r_busy    <= 1'b1;
                    end
                end

                S_START: begin
                    if (w_bit_end) begin
                        r_state   <= S_DATA;
                        r_cnt     <= '0;
                        r_bit_idx <= '0;
                        r_txd     <= r_shift[0];
                    end else begin
                        r_cnt <= r_cnt + c_div_one;
                    end
                end

                S_DATA: begin
                    if (w_bit_end) begin
                        r_cnt <= '0;
                        if (r_bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            r_state <= S_PARITY;
                            r_txd   <= r_parity;
`else
                            r_state <= S_STOP;
                            r_txd   <= 1'b1;
                            // One-cycle stop bit: its first cycle is its last.
                            r_done  <= (r_div_q == '0);
`endif
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                            r_shift   <= r_shift >> 1;
                            r_txd     <= r_shift[1];
                        end
                    end else begin
                        r_cnt <= r_cnt + c_div_one;
                    end
                end

`ifdef UART_TX_PARITY_EN
                S_PARITY: begin
                    if (w_bit_end) begin
                        r_state <= S_STOP;
                        r_cnt   <= '0;
                        r_txd   <= 1'b1;
                        r_done  <= (r_div_q == '0);
                    end else begin
                        r_cnt <= r_cnt + c_div_one;
                    end
                end
`endif

                S_STOP: begin
                    if (w_bit_end) begin
                        r_cnt <= '0;
                        if (w_pop) begin
                            r_state   <= S_START;
                            r_div_q   <= baud_div;
                            r_shift   <= w_head;
`ifdef UART_TX_PARITY_EN
                            r_parity  <= ^w_head;
`endif
                            r_txd     <= 1'b0;
                        end else begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end else begin
                        r_cnt  <= r_cnt + c_div_one;
                        // Registered pulse: raise it on entry to the last
                        // stop cycle. r_cnt < r_div_q here, so no underflow.
                        r_done <= (r_cnt == (r_div_q - c_div_one));
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                    r_cnt   <= '0;
                    r_txd   <= 1'b1;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign txd     = r_txd;
    assign tx_busy = r_busy;
    assign tx_done = r_done;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_engine
// Description : Self-checking bench for uart_tx_engine. A byte queue models
//               the FIFO contents; expected txd/tx_done/tx_busy waveforms are
//               built from the frame format (start, 8 data LSB first,
//               optional even parity, stop) with bit length baud_div+1.
//               Honours UART_TX_PARITY_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_uart_tx_engine;

    localparam int FIFO_DEPTH = 8;
    localparam int DIV_WIDTH  = 16;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif

    logic                 hclk = 1'b0;
    logic                 hrst_n = 1'b0;
    logic [DIV_WIDTH-1:0] baud_div = '0;
    logic                 tx_en = 1'b0;
    logic                 txd;
    logic                 tx_busy;
    logic                 tx_done;

    int n_cmp = 0;
    int n_bad = 0;
    int last_wait;
    logic [7:0] model_q[$];

    uart_tx_engine_if #(.FIFO_DEPTH(FIFO_DEPTH)) bus ();

    uart_tx_engine #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .DIV_WIDTH  (DIV_WIDTH)
    ) dut (
        .hclk     (hclk),
        .hrst_n   (hrst_n),
        .wr_bus   (bus.slave),
        .baud_div (baud_div),
        .tx_en    (tx_en),
        .txd      (txd),
        .tx_busy  (tx_busy),
        .tx_done  (tx_done)
    );

    always #5 hclk = ~hclk;

    task automatic check_value(input string tag, input logic [31:0] got,
                               input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Expected line level for bit position idx of a frame carrying b.
    function automatic logic frame_bit(input logic [7:0] b, input int idx);
        if (idx == 0) return 1'b0;
        if (idx <= 8) return b[idx-1];
        if (idx == 9 && NBITS == 11) return ^b;
        return 1'b1;
    endfunction

    // Push one byte; returns one negedge later, when flags reflect the push.
    task automatic write_byte(input logic [7:0] b, input bit to_model);
        bus.wr_en   = 1'b1;
        bus.wr_data = b;
        if (to_model) model_q.push_back(b);
        @(negedge hclk);
        bus.wr_en = 1'b0;
    endtask

    // Waits for the start bit, then checks every cycle of all frames held in
    // model_q (back to back, no gaps), then checks the line has gone idle.
    // mode[0]: scramble baud_div during the first start cycle.
    // mode[1]: drop tx_en during the first start cycle.
    task automatic expect_frames(input int div, input int mode, input int exp_wait);
        logic [7:0] b;
        int waited;
        waited = 0;
        while (txd !== 1'b0 && waited < 200) begin
            @(negedge hclk);
            waited++;
        end
        last_wait = waited;
        check_value("start_latency", waited, exp_wait);
        check_value("start_seen", {31'b0, txd}, 0);
        if (txd === 1'b0) begin
            while (model_q.size() > 0) begin
                b = model_q.pop_front();
                for (int bi = 0; bi < NBITS; bi++) begin
                    for (int c = 0; c <= div; c++) begin
                        check_value("txd", {31'b0, txd}, {31'b0, frame_bit(b, bi)});
                        check_value("tx_busy", {31'b0, tx_busy}, 1);
                        check_value("tx_done", {31'b0, tx_done},
                                    (bi == NBITS-1 && c == div) ? 1 : 0);
                        if (bi == 0 && c == 0) begin
                            if (mode[0]) baud_div = DIV_WIDTH'($urandom);
                            if (mode[1]) tx_en = 1'b0;
                        end
                        @(negedge hclk);
                    end
                end
            end
        end
        check_value("idle_txd", {31'b0, txd}, 1);
        check_value("idle_busy", {31'b0, tx_busy}, 0);
        check_value("idle_done", {31'b0, tx_done}, 0);
    endtask

    initial begin
        int n;
        int div;
        logic [7:0] b2;

        bus.wr_en   = 1'b0;
        bus.wr_data = '0;
        bus.ovf_clr = 1'b0;

        // ---------------- reset values ----------------
        repeat (3) @(negedge hclk);
        check_value("rst_txd", {31'b0, txd}, 1);
        check_value("rst_busy", {31'b0, tx_busy}, 0);
        check_value("rst_done", {31'b0, tx_done}, 0);
        check_value("rst_ovf", {31'b0, bus.ovf_err}, 0);
        check_value("rst_empty", {31'b0, bus.fifo_empty}, 1);
        check_value("rst_full", {31'b0, bus.fifo_full}, 0);
        check_value("rst_level", {28'b0, bus.fifo_level}, 0);
        hrst_n = 1'b1;
        @(negedge hclk);
        check_value("post_rst_txd", {31'b0, txd}, 1);

        // ---------------- single 0xA5 frame, baud_div=3 ----------------
        baud_div = 16'd3;
        tx_en    = 1'b1;
        write_byte(8'hA5, 1'b1);
        check_value("a5_level", {28'b0, bus.fifo_level}, 1);
        check_value("a5_txd_pre", {31'b0, txd}, 1);
        expect_frames(3, 0, 1);

        // ---------------- back-to-back 0x00,0xFF at baud_div=0 ----------------
        tx_en = 1'b0;
        write_byte(8'h00, 1'b1);
        write_byte(8'hFF, 1'b1);
        baud_div = 16'd0;
        tx_en    = 1'b1;
        expect_frames(0, 0, 1);

        // ---------------- randomized bursts ----------------
        for (int it = 0; it < 6; it++) begin
            tx_en = 1'b0;
            n   = int'($urandom_range(1, 4));
            div = int'($urandom_range(0, 4));
            for (int k = 0; k < n; k++) write_byte(8'($urandom), 1'b1);
            check_value("burst_level", {28'b0, bus.fifo_level}, n);
            baud_div = DIV_WIDTH'(div);
            tx_en    = 1'b1;
            expect_frames(div, (n == 1) ? 1 : 0, 1);
        end

        // ---------------- tx_en dropped mid-frame ----------------
        tx_en = 1'b0;
        write_byte(8'($urandom), 1'b1);
        b2 = 8'($urandom);
        write_byte(b2, 1'b0);
        baud_div = 16'd2;
        tx_en    = 1'b1;
        expect_frames(2, 2, 1);
        repeat (5) @(negedge hclk);
        check_value("hold_txd", {31'b0, txd}, 1);
        check_value("hold_level", {28'b0, bus.fifo_level}, 1);
        model_q.push_back(b2);
        tx_en = 1'b1;
        expect_frames(2, 0, 1);

        // ---------------- overflow ----------------
        tx_en    = 1'b0;
        baud_div = 16'd0;
        for (int k = 0; k < 9; k++) begin
            write_byte(8'($urandom), k < FIFO_DEPTH);
            check_value("ovf_level", {28'b0, bus.fifo_level}, (k < FIFO_DEPTH) ? k + 1 : FIFO_DEPTH);
        end
        check_value("ovf_full", {31'b0, bus.fifo_full}, 1);
        check_value("ovf_empty", {31'b0, bus.fifo_empty}, 0);
        check_value("ovf_set", {31'b0, bus.ovf_err}, 1);
        check_value("ovf_txd", {31'b0, txd}, 1);
        bus.ovf_clr = 1'b1;
        @(negedge hclk);
        bus.ovf_clr = 1'b0;
        check_value("ovf_clr", {31'b0, bus.ovf_err}, 0);
        write_byte(8'h5A, 1'b0);
        check_value("ovf_reset", {31'b0, bus.ovf_err}, 1);
        bus.ovf_clr = 1'b1;
        write_byte(8'h3C, 1'b0);
        bus.ovf_clr = 1'b0;
        check_value("ovf_clr_prio", {31'b0, bus.ovf_err}, 0);
        check_value("ovf_drop_level", {28'b0, bus.fifo_level}, FIFO_DEPTH);

        // ---------------- write on the pop cycle while full ----------------
        tx_en = 1'b1;
        b2 = 8'($urandom);
        write_byte(b2, 1'b1);
        check_value("fullpop_level", {28'b0, bus.fifo_level}, FIFO_DEPTH);
        check_value("fullpop_full", {31'b0, bus.fifo_full}, 1);
        check_value("fullpop_ovf", {31'b0, bus.ovf_err}, 0);
        expect_frames(0, 0, 0);

        // ---------------- reset in the middle of DATA ----------------
        tx_en = 1'b0;
        for (int k = 0; k < 3; k++) write_byte(8'($urandom), 1'b0);
        baud_div = 16'd3;
        tx_en    = 1'b1;
        repeat (10) @(negedge hclk);
        check_value("mid_busy", {31'b0, tx_busy}, 1);
        hrst_n = 1'b0;
        #1;
        check_value("arst_txd", {31'b0, txd}, 1);
        check_value("arst_busy", {31'b0, tx_busy}, 0);
        check_value("arst_level", {28'b0, bus.fifo_level}, 0);
        @(negedge hclk);
        hrst_n = 1'b1;
        @(negedge hclk);
        check_value("rel_level", {28'b0, bus.fifo_level}, 0);
        check_value("rel_empty", {31'b0, bus.fifo_empty}, 1);
        repeat (4) @(negedge hclk);
        check_value("rel_txd", {31'b0, txd}, 1);
        check_value("rel_busy", {31'b0, tx_busy}, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_tx_engine.md
# uart_tx_engine

Transmit stage of the UART-to-AHB bridge. It buffers bytes written by the AHB slave front end in a small synchronous FIFO and serialises them onto `txd` as 8N1 frames (8E1 when parity is compiled in). The bit period is set by a programmable divider. The block sits directly downstream of the AHB register decode and drives the bridge's `txd` and `tx_busy` status outputs.

## Interface
- `FIFO_DEPTH`, default 8: TX FIFO entries. Must be a power of two, ≥2.
- `DIV_WIDTH`, default 16: width of the baud divisor.

- `hclk`  in  1  system clock; everything is synchronous to its rising edge.
- `hrst_n`  in  1  asynchronous, active-low reset.
- `wr_en`  in  1  push `wr_data` into the FIFO this cycle.
- `wr_data`  in  8  byte to transmit.
- `fifo_full`  out  1  FIFO holds FIFO_DEPTH entries.
- `fifo_empty`  out  1  FIFO holds 0 entries.
- `fifo_level`  out  $clog2(FIFO_DEPTH)+1  current entry count.
- `ovf_err`  out  1  sticky flag: a write was dropped.
- `ovf_clr`  in  1  clears `ovf_err`.
- `baud_div`  in  DIV_WIDTH  bit period minus one, in `hclk` cycles.
- `tx_en`  in  1  permits new frames to start.
- `txd`  out  1  serial output, idle high.
- `tx_busy`  out  1  a frame is in progress (any state other than IDLE).
- `tx_done`  out  1  one-cycle pulse on the last cycle of each stop bit.

## Operation
- Reset values: `txd`=1, `tx_busy`=0, `tx_done`=0, `ovf_err`=0, `fifo_empty`=1, `fifo_full`=0, `fifo_level`=0. Pointers are cleared and the FSM returns to IDLE. Reset asserted mid-frame aborts the frame immediately, and `txd` goes high asynchronously.
- FIFO:
  - Binary read and write pointers with one extra wrap bit; full/empty derive from pointer comparison.
  - A write when full with no pop in the same cycle is dropped and sets `ovf_err`.
  - A write when full in the same cycle as a pop is accepted, and the level is unchanged.
  - `ovf_clr` has priority over a same-cycle set.
- FSM states: IDLE, START, DATA, PARITY (only when the macro is defined), STOP.
  - IDLE → START: when `tx_en` && !`fifo_empty`. The head byte pops into the shift register and `baud_div` is latched into `div_q`.
  - START → DATA: after `div_q`+1 cycles.
  - DATA: shifts LSB first. After 8 bits it goes to PARITY or STOP.
  - PARITY → STOP: after `div_q`+1 cycles.
  - STOP, on its final cycle: pulse `tx_done`. If `tx_en` && !`fifo_empty`, pop and go directly to START with no idle gap; otherwise go to IDLE.
- Bit timing: a cycle counter runs 0..`div_q` and resets at each bit boundary, so every bit lasts `div_q`+1 cycles. `baud_div`=0 gives one cycle per bit.
- Changes to `baud_div` mid-frame have no effect until the next frame start.
- Deasserting `tx_en` mid-frame lets the current frame complete; no new frame starts.
- `txd` is registered (no glitches). Its value is 0 in START, the data bit in DATA, the parity bit in PARITY, and 1 in STOP/IDLE.

## Timing
- Pop at cycle T (IDLE with the condition true). `txd` falls at T+1 and `tx_busy` rises at T+1.
- Frame length: 10×(`div_q`+1) cycles, or 11×(`div_q`+1) with parity.
- `tx_done` is high on cycle T+frame_length.
- `tx_busy` falls the cycle after `tx_done` when no back-to-back pop occurs.
- Back-to-back: the next start bit begins the cycle after the last stop cycle.
- FIFO flags and `fifo_level` update the cycle after the push or pop edge.

## Configuration
- `UART_TX_PARITY_EN` defined: the PARITY state is present and an even-parity bit (XOR of the 8 data bits) is sent between the data bits and the stop bit, giving 11-bit frames.
- `UART_TX_PARITY_EN` not defined: the PARITY state and its logic are absent, giving 10-bit 8N1 frames.

## Test plan
- Reset, `baud_div`=3, `tx_en`=1, write 0xA5 → `txd` sequence 0,1,0,1,0,0,1,0,1,1, each level held 4 cycles; `tx_done` pulses 40 cycles after the pop; `tx_busy` is 0 afterwards.
- With `UART_TX_PARITY_EN`, same stimulus → parity bit 0 inserted before stop; `tx_done` comes 44 cycles after the pop.
- `tx_en`=0, write 9 bytes with FIFO_DEPTH=8 → `fifo_full`=1, `fifo_level`=8, `ovf_err`=1; `txd` stays 1. Then `ovf_clr` → `ovf_err`=0.
- FIFO full, `tx_en` raised, write on the pop cycle → write accepted, `fifo_level` stays 8, `ovf_err` stays 0.
- Write 0x00 and 0xFF, `baud_div`=0 → 20 consecutive frame cycles with no idle gap; `tx_done` on cycles 10 and 20.
- Assert `hrst_n`=0 in the middle of the DATA state → `txd`=1 immediately, `tx_busy`=0, `fifo_level`=0 after reset release.
